signed_subtractor_pipe: RTL and testbench

Pipelined two's-complement subtractor computing d = a − b with signed-overflow detection, optional saturation, and a sticky overflow flag plus overflow event counter. It is the subtraction counterpart of the team's combinational signed adder. It sits on a valid/ready stream between an operand producer and a result consumer, so arithmetic datapaths can use subtraction at full throughput under back-pressure.

---
 rtl/signed_arith_pkg.sv | 21 ++
 rtl/signed_sub_core.sv | 18 +
 rtl/signed_subtractor_pipe.sv | 122 ++++++++++++
 tb/tb_signed_subtractor_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_arith_pkg.sv
// Shared signed-arithmetic helpers: default width, subtraction overflow rule and
// the signed saturation limits used by the signed adder and subtractor blocks.
package signed_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 64;

    // Overflow only when the operand signs differ and the result sign leaves a's sign.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width + 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/signed_sub_core.sv
// Combinational two's-complement difference a - b with signed-overflow flag.
module signed_sub_core
    import signed_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] raw,
    output logic             ovf
);

    always_comb begin
        raw = a + ~b + WIDTH'(1);
        ovf = sub_overflow(a[WIDTH-1], b[WIDTH-1], raw[WIDTH-1]);
    end

endmodule

// File: rtl/signed_subtractor_pipe.sv
// Two-stage valid/ready pipelined signed subtractor with optional saturation,
// sticky overflow flag and saturating overflow event counter.
module signed_subtractor_pipe
    import signed_arith_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             overflow,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_raw;
    logic             s1_ovf;
    logic             s1_amsb;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_d;
    logic             s2_ovf;

    logic [WIDTH-1:0] core_raw;
    logic             core_ovf;
    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] s2_d_next;
    logic             out_xfer;
    logic             ovf_xfer;

    signed_sub_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .raw (core_raw),
        .ovf (core_ovf)
    );

    // Handshake: a beat moves when valid && ready on the same rising edge. A stage
    // may load when it is empty or its downstream is loading this cycle, so
    // in_ready depends only on out_ready and stage occupancy, never on in_valid.
    always_comb begin
        adv2     = !s2_valid || out_ready;
        adv1     = !s1_valid || adv2;
        in_ready = adv1;
        out_xfer = s2_valid && out_ready;
        ovf_xfer = out_xfer && s2_ovf;
    end

    always_comb begin
        s2_d_next = s1_raw;
        if ((SATURATE != 0) && s1_ovf) begin
            s2_d_next = s1_amsb ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_ovf   <= 1'b0;
            s1_amsb  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_raw  <= core_raw;
                s1_ovf  <= core_ovf;
                s1_amsb <= a[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_d     <= '0;
            s2_ovf   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_d   <= s2_d_next;
                s2_ovf <= s1_ovf;
            end
        end
    end

    // A delivered overflow beats a simultaneous clear: the event restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (ovf_xfer) begin
            sticky_ovf <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

    assign out_valid = s2_valid;
    assign d         = s2_d;
    assign overflow  = s2_ovf;

endmodule

// File: tb/tb_signed_subtractor_pipe.sv
// Bench for signed_subtractor_pipe: wrap and saturate instances share stimulus
// and are checked against a plain-integer reference of signed subtraction.
module tb_signed_subtractor_pipe;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, out_ready, clr_sticky;
    logic [W-1:0]  a, b;
    logic          in_ready_w, out_valid_w, ovf_w, sticky_w;
    logic          in_ready_s, out_valid_s, ovf_s, sticky_s;
    logic [W-1:0]  d_w, d_s;
    logic [CW-1:0] cnt_w, cnt_s;

    int            errors = 0;
    int            checks = 0;
    logic [16:0]   exp_q[$];
    logic          ref_sticky = 1'b0;
    int            ref_count = 0;

    always #5 clk = ~clk;

    signed_subtractor_pipe #(.WIDTH(W), .SATURATE(0), .CNT_W(CW)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
        .d(d_w), .overflow(ovf_w), .sticky_ovf(sticky_w),
        .clr_sticky(clr_sticky), .ovf_count(cnt_w)
    );

    signed_subtractor_pipe #(.WIDTH(W), .SATURATE(1), .CNT_W(CW)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .d(d_s), .overflow(ovf_s), .sticky_ovf(sticky_s),
        .clr_sticky(clr_sticky), .ovf_count(cnt_s)
    );

    // Reference: true integer difference, out-of-range means overflow.
    // Packed as {ovf, saturated d, wrapped d}.
    function automatic logic [16:0] ref_model(input logic [7:0] x, input logic [7:0] y);
        int         diff;
        logic       ovf;
        logic [7:0] wrap;
        logic [7:0] sat;
        diff = int'($signed(x)) - int'($signed(y));
        ovf  = (diff > 127) || (diff < -128);
        wrap = 8'(diff);
        sat  = ovf ? ((diff > 0) ? 8'h7F : 8'h80) : wrap;
        return {ovf, sat, wrap};
    endfunction

    task automatic drive_cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                               input logic ordy, input logic clr);
        @(negedge clk);
        in_valid   = iv;
        a          = ia;
        b          = ib;
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        if (iv && in_ready_w) exp_q.push_back(ref_model(ia, ib));
    endtask

    task automatic sb_take(output logic [16:0] e);
        if (exp_q.size() == 0) begin
            e = 'x;
        end else begin
            e = exp_q.pop_front();
            if (e[16]) begin
                ref_sticky = 1'b1;
                if (ref_count < 255) ref_count++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready_w !== 1'b1 || in_ready_s !== 1'b1 || out_valid_w !== 1'b0 || out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got in_ready=%b%b out_valid=%b%b required in_ready=11 out_valid=00",
                     in_ready_w, in_ready_s, out_valid_w, out_valid_s);
        end
        checks++;
        if (d_w !== 8'h00 || d_s !== 8'h00 || ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got d=%h/%h ovf=%b/%b required d=00 ovf=0", d_w, d_s, ovf_w, ovf_s);
        end
        checks++;
        if (sticky_w !== 1'b0 || cnt_w !== 8'h00 || sticky_s !== 1'b0 || cnt_s !== 8'h00) begin
            errors++;
            $display("FAIL reset_sticky: got sticky=%b count=%h required sticky=0 count=00", sticky_w, cnt_w);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0]  va [5] = '{8'h05, 8'h80, 8'h50, 8'h80, 8'h00};
        logic [7:0]  vb [5] = '{8'h03, 8'h80, 8'hB0, 8'h01, 8'h80};
        logic [16:0] e;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, va[i], vb[i], 1'b1, 1'b0);
            checks++;
            if (in_ready_w !== 1'b1) begin
                errors++;
                $display("FAIL basic_accept[%0d]: got in_ready=%b required 1", i, in_ready_w);
            end
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            checks++;
            if (out_valid_w !== 1'b0) begin
                errors++;
                $display("FAIL basic_early[%0d]: got out_valid=%b one cycle after accept required 0", i, out_valid_w);
            end
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            checks++;
            if (out_valid_w !== 1'b1 || out_valid_s !== 1'b1) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got out_valid=%b%b two cycles after accept required 11",
                         i, out_valid_w, out_valid_s);
            end
            if (out_valid_w) begin
                sb_take(e);
                checks++;
                if (d_w !== e[7:0] || ovf_w !== e[16]) begin
                    errors++;
                    $display("FAIL basic_wrap[%0d]: got d=%h ovf=%b required d=%h ovf=%b", i, d_w, ovf_w, e[7:0], e[16]);
                end
                checks++;
                if (d_s !== e[15:8] || ovf_s !== e[16]) begin
                    errors++;
                    $display("FAIL basic_sat[%0d]: got d=%h ovf=%b required d=%h ovf=%b", i, d_s, ovf_s, e[15:8], e[16]);
                end
            end
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            checks++;
            if (sticky_w !== ref_sticky || cnt_w !== 8'(ref_count) || sticky_s !== ref_sticky || cnt_s !== 8'(ref_count)) begin
                errors++;
                $display("FAIL basic_sticky[%0d]: got sticky=%b count=%0d required sticky=%b count=%0d",
                         i, sticky_w, cnt_w, ref_sticky, ref_count);
            end
        end
    endtask

    task automatic test_backpressure();
        int          sent, got, inflight;
        logic        iv, ordy, exp_ir, stalled_prev, saw_block;
        logic [7:0]  d_prev_w, d_prev_s;
        logic [16:0] e;
        sent = 0; got = 0; inflight = 0;
        stalled_prev = 1'b0; saw_block = 1'b0;
        d_prev_w = '0; d_prev_s = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            iv   = (sent < 5);
            ordy = !(cyc >= 3 && cyc < 7);
            drive_cycle(iv, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ordy, 1'b0);
            exp_ir = !(inflight == 2 && !ordy);
            checks++;
            if (in_ready_w !== exp_ir || in_ready_s !== exp_ir) begin
                errors++;
                $display("FAIL bp_in_ready[cyc %0d]: got %b%b required %b", cyc, in_ready_w, in_ready_s, exp_ir);
            end
            if (!in_ready_w) saw_block = 1'b1;
            if (stalled_prev) begin
                checks++;
                if (out_valid_w !== 1'b1 || d_w !== d_prev_w || d_s !== d_prev_s) begin
                    errors++;
                    $display("FAIL bp_hold[cyc %0d]: got valid=%b d=%h/%h required valid=1 d=%h/%h",
                             cyc, out_valid_w, d_w, d_s, d_prev_w, d_prev_s);
                end
            end
            if (out_valid_w && ordy) begin
                sb_take(e);
                checks++;
                if (d_w !== e[7:0] || d_s !== e[15:8] || ovf_w !== e[16] || ovf_s !== e[16]) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got d=%h/%h ovf=%b/%b required d=%h/%h ovf=%b",
                             got, d_w, d_s, ovf_w, ovf_s, e[7:0], e[15:8], e[16]);
                end
                got++;
                inflight--;
            end
            if (iv && in_ready_w) begin
                sent++;
                inflight++;
            end
            stalled_prev = out_valid_w && !ordy;
            d_prev_w = d_w;
            d_prev_s = d_s;
        end
        checks++;
        if (got != 5 || exp_q.size() != 0 || !saw_block) begin
            errors++;
            $display("FAIL bp_complete: got delivered=%0d pending=%0d blocked=%b required 5/0/1",
                     got, exp_q.size(), saw_block);
        end
    endtask

    task automatic test_full_rate();
        int          got;
        logic [16:0] e;
        got = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            drive_cycle(cyc < 20, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            checks++;
            if (in_ready_w !== 1'b1 || (cyc >= 2 && out_valid_w !== 1'b1)) begin
                errors++;
                $display("FAIL full_rate[cyc %0d]: got in_ready=%b out_valid=%b required 1/%b",
                         cyc, in_ready_w, out_valid_w, cyc >= 2);
            end
            if (out_valid_w) begin
                sb_take(e);
                checks++;
                if (d_w !== e[7:0] || d_s !== e[15:8] || ovf_w !== e[16]) begin
                    errors++;
                    $display("FAIL full_rate_data[%0d]: got d=%h/%h ovf=%b required d=%h/%h ovf=%b",
                             got, d_w, d_s, ovf_w, e[7:0], e[15:8], e[16]);
                end
                got++;
            end
        end
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL full_rate_count: got %0d results in 22 cycles required 20", got);
        end
    endtask

    task automatic test_counter();
        logic [16:0] e;
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        ref_sticky = 1'b0; ref_count = 0;
        checks++;
        if (sticky_w !== 1'b0 || cnt_w !== 8'h00) begin
            errors++;
            $display("FAIL clr_initial: got sticky=%b count=%0d required 0/0", sticky_w, cnt_w);
        end
        for (int cyc = 0; cyc < 302; cyc++) begin
            drive_cycle(cyc < 300, 8'($urandom_range(64, 127)), 8'($urandom_range(128, 191)), 1'b1, 1'b0);
            if (out_valid_w) begin
                sb_take(e);
                checks++;
                if (d_w !== e[7:0] || d_s !== e[15:8] || ovf_w !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_stream[%0d]: got d=%h/%h ovf=%b required d=%h/%h ovf=1",
                             cyc, d_w, d_s, ovf_w, e[7:0], e[15:8]);
                end
            end
        end
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        checks++;
        if (cnt_w !== 8'(ref_count) || cnt_s !== 8'(ref_count) || sticky_w !== 1'b1 || ref_count != 255) begin
            errors++;
            $display("FAIL count_saturate: got count=%0d sticky=%b required count=%0d sticky=1 (model 255)",
                     cnt_w, sticky_w, ref_count);
        end
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        ref_sticky = 1'b0; ref_count = 0;
        checks++;
        if (sticky_w !== 1'b0 || cnt_w !== 8'h00) begin
            errors++;
            $display("FAIL clr_alone: got sticky=%b count=%0d required 0/0", sticky_w, cnt_w);
        end
        drive_cycle(1'b1, 8'h50, 8'hB0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        if (out_valid_w) sb_take(e);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        checks++;
        if (out_valid_w !== 1'b1 || ovf_w !== 1'b1 || cnt_w !== 8'd1) begin
            errors++;
            $display("FAIL clr_coincide_setup: got valid=%b ovf=%b count=%0d required 1/1/1",
                     out_valid_w, ovf_w, cnt_w);
        end
        if (out_valid_w) sb_take(e);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        ref_sticky = 1'b1; ref_count = 1;
        checks++;
        if (sticky_w !== ref_sticky || cnt_w !== 8'(ref_count) || sticky_s !== ref_sticky || cnt_s !== 8'(ref_count)) begin
            errors++;
            $display("FAIL clr_coincide: got sticky=%b count=%0d required sticky=1 count=1", sticky_w, cnt_w);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        drive_cycle(1'b1, 8'h50, 8'hB0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h05, 8'h03, 1'b0, 1'b0);
        checks++;
        if (in_ready_w !== 1'b0 || out_valid_w !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready=%b out_valid=%b required 0/1", in_ready_w, out_valid_w);
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0 || out_valid_s !== 1'b0 || d_w !== 8'h00 || d_s !== 8'h00 ||
            ovf_w !== 1'b0 || sticky_w !== 1'b0 || cnt_w !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got in_ready=%b out_valid=%b d=%h/%h ovf=%b sticky=%b count=%0d required 1/0/00/00/0/0/0",
                     in_ready_w, out_valid_w, d_w, d_s, ovf_w, sticky_w, cnt_w);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        ref_sticky = 1'b0; ref_count = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            checks++;
            if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale[%0d]: got out_valid=%b%b required 00", i, out_valid_w, out_valid_s);
            end
        end
        drive_cycle(1'b1, 8'h7F, 8'hFF, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        checks++;
        if (out_valid_w !== 1'b0) begin
            errors++;
            $display("FAIL mid_early: got out_valid=%b required 0", out_valid_w);
        end
        drive_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        sb_take(e);
        checks++;
        if (out_valid_w !== 1'b1 || d_w !== e[7:0] || d_s !== e[15:8] || ovf_w !== e[16]) begin
            errors++;
            $display("FAIL mid_after: got valid=%b d=%h/%h ovf=%b required valid=1 d=%h/%h ovf=%b",
                     out_valid_w, d_w, d_s, ovf_w, e[7:0], e[15:8], e[16]);
        end
    endtask

    initial begin
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_full_rate();
        test_counter();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
